// File: rtl/rs_alu.sv
// Reservation station for the ALU pipe: two dispatch slots, two CDB snoop buses,
// lowest-index-first issue to one execution unit.
module rs_alu #(
    parameter int ENT_NUM    = 4,
    parameter int ENT_SEL    = 2,
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_we_1,
    input  logic [ENT_SEL-1:0]    i_wsel_1,
    input  logic [OP_WIDTH-1:0]   i_op_1,
    input  logic [TAG_WIDTH-1:0]  i_dst_tag_1,
    input  logic                  i_src1_rdy_1,
    input  logic [DATA_WIDTH-1:0] i_src1_data_1,
    input  logic [TAG_WIDTH-1:0]  i_src1_tag_1,
    input  logic                  i_src2_rdy_1,
    input  logic [DATA_WIDTH-1:0] i_src2_data_1,
    input  logic [TAG_WIDTH-1:0]  i_src2_tag_1,
    input  logic                  i_we_2,
    input  logic [ENT_SEL-1:0]    i_wsel_2,
    input  logic [OP_WIDTH-1:0]   i_op_2,
    input  logic [TAG_WIDTH-1:0]  i_dst_tag_2,
    input  logic                  i_src1_rdy_2,
    input  logic [DATA_WIDTH-1:0] i_src1_data_2,
    input  logic [TAG_WIDTH-1:0]  i_src1_tag_2,
    input  logic                  i_src2_rdy_2,
    input  logic [DATA_WIDTH-1:0] i_src2_data_2,
    input  logic [TAG_WIDTH-1:0]  i_src2_tag_2,
    input  logic                  i_cdb_vld_1,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag_1,
    input  logic [DATA_WIDTH-1:0] i_cdb_data_1,
    input  logic                  i_cdb_vld_2,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag_2,
    input  logic [DATA_WIDTH-1:0] i_cdb_data_2,
    input  logic                  i_issue_rdy,
    output logic [ENT_NUM-1:0]    o_busy_vec,
    output logic                  o_issue_vld,
    output logic [OP_WIDTH-1:0]   o_issue_op,
    output logic [DATA_WIDTH-1:0] o_issue_src1,
    output logic [DATA_WIDTH-1:0] o_issue_src2,
    output logic [TAG_WIDTH-1:0]  o_issue_dst_tag
);

    // Resolve one operand against both CDBs; CDB 2 takes precedence. Result is {rdy, data}.
    function automatic logic [DATA_WIDTH:0] wake_operand(
        input logic                  rdy,
        input logic [TAG_WIDTH-1:0]  tag,
        input logic [DATA_WIDTH-1:0] data,
        input logic                  vld1,
        input logic [TAG_WIDTH-1:0]  tag1,
        input logic [DATA_WIDTH-1:0] data1,
        input logic                  vld2,
        input logic [TAG_WIDTH-1:0]  tag2,
        input logic [DATA_WIDTH-1:0] data2
    );
        logic [DATA_WIDTH:0] res;
        if (!rdy && vld2 && (tag == tag2)) begin
            res = {1'b1, data2};
        end else if (!rdy && vld1 && (tag == tag1)) begin
            res = {1'b1, data1};
        end else begin
            res = {rdy, data};
        end
        return res;
    endfunction

    logic [ENT_NUM-1:0]                 r_busy;
    logic [ENT_NUM-1:0][OP_WIDTH-1:0]   r_op;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  r_dst_tag;
    logic [ENT_NUM-1:0]                 r_s1_rdy;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  r_s1_tag;
    logic [ENT_NUM-1:0][DATA_WIDTH-1:0] r_s1_data;
    logic [ENT_NUM-1:0]                 r_s2_rdy;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  r_s2_tag;
    logic [ENT_NUM-1:0][DATA_WIDTH-1:0] r_s2_data;

    logic [ENT_NUM-1:0]                 w_busy_nxt;
    logic [ENT_NUM-1:0][OP_WIDTH-1:0]   w_op_nxt;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  w_dst_tag_nxt;
    logic [ENT_NUM-1:0]                 w_s1_rdy_nxt;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  w_s1_tag_nxt;
    logic [ENT_NUM-1:0][DATA_WIDTH-1:0] w_s1_data_nxt;
    logic [ENT_NUM-1:0]                 w_s2_rdy_nxt;
    logic [ENT_NUM-1:0][TAG_WIDTH-1:0]  w_s2_tag_nxt;
    logic [ENT_NUM-1:0][DATA_WIDTH-1:0] w_s2_data_nxt;

    logic [ENT_NUM-1:0][DATA_WIDTH:0]   w_s1_wake;
    logic [ENT_NUM-1:0][DATA_WIDTH:0]   w_s2_wake;
    logic [DATA_WIDTH:0]                w_d1_s1;
    logic [DATA_WIDTH:0]                w_d1_s2;
    logic [DATA_WIDTH:0]                w_d2_s1;
    logic [DATA_WIDTH:0]                w_d2_s2;

    logic [ENT_NUM-1:0]                 w_ready;
    logic [ENT_SEL-1:0]                 w_sel;
    logic                               w_issue_vld;
    logic                               w_fire;

    // Dispatch/CDB bypass: operands arriving this cycle also see this cycle's broadcasts.
    assign w_d1_s1 = wake_operand(i_src1_rdy_1, i_src1_tag_1, i_src1_data_1,
                                  i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                  i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);
    assign w_d1_s2 = wake_operand(i_src2_rdy_1, i_src2_tag_1, i_src2_data_1,
                                  i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                  i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);
    assign w_d2_s1 = wake_operand(i_src1_rdy_2, i_src1_tag_2, i_src1_data_2,
                                  i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                  i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);
    assign w_d2_s2 = wake_operand(i_src2_rdy_2, i_src2_tag_2, i_src2_data_2,
                                  i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                  i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);

    for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
        assign w_s1_wake[g] = wake_operand(r_s1_rdy[g], r_s1_tag[g], r_s1_data[g],
                                           i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                           i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);
        assign w_s2_wake[g] = wake_operand(r_s2_rdy[g], r_s2_tag[g], r_s2_data[g],
                                           i_cdb_vld_1, i_cdb_tag_1, i_cdb_data_1,
                                           i_cdb_vld_2, i_cdb_tag_2, i_cdb_data_2);
        assign w_ready[g]   = r_busy[g] & r_s1_rdy[g] & r_s2_rdy[g];
    end

    // Lowest-index ready entry wins; scanning downward leaves the lowest hit last.
    always_comb begin
        w_sel = '0;
        for (int i = ENT_NUM - 1; i >= 0; i--) begin
            w_sel = w_ready[i] ? ENT_SEL'(i) : w_sel;
        end
    end

    assign w_issue_vld     = |w_ready;
    assign w_fire          = w_issue_vld & i_issue_rdy;
    assign o_issue_vld     = w_issue_vld;
    assign o_issue_op      = w_issue_vld ? r_op[w_sel]      : '0;
    assign o_issue_src1    = w_issue_vld ? r_s1_data[w_sel] : '0;
    assign o_issue_src2    = w_issue_vld ? r_s2_data[w_sel] : '0;
    assign o_issue_dst_tag = w_issue_vld ? r_dst_tag[w_sel] : '0;
    assign o_busy_vec      = r_busy;

    // Per-entry next state: flush, then dispatch (slot 2 over slot 1), then issue/wakeup.
    always_comb begin
        w_busy_nxt    = r_busy;
        w_op_nxt      = r_op;
        w_dst_tag_nxt = r_dst_tag;
        w_s1_rdy_nxt  = r_s1_rdy;
        w_s1_tag_nxt  = r_s1_tag;
        w_s1_data_nxt = r_s1_data;
        w_s2_rdy_nxt  = r_s2_rdy;
        w_s2_tag_nxt  = r_s2_tag;
        w_s2_data_nxt = r_s2_data;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (i_flush) begin
                w_busy_nxt[i] = 1'b0;
            end else if (i_we_2 && (i_wsel_2 == ENT_SEL'(i))) begin
                w_busy_nxt[i]    = 1'b1;
                w_op_nxt[i]      = i_op_2;
                w_dst_tag_nxt[i] = i_dst_tag_2;
                w_s1_tag_nxt[i]  = i_src1_tag_2;
                w_s1_rdy_nxt[i]  = w_d2_s1[DATA_WIDTH];
                w_s1_data_nxt[i] = w_d2_s1[DATA_WIDTH-1:0];
                w_s2_tag_nxt[i]  = i_src2_tag_2;
                w_s2_rdy_nxt[i]  = w_d2_s2[DATA_WIDTH];
                w_s2_data_nxt[i] = w_d2_s2[DATA_WIDTH-1:0];
            end else if (i_we_1 && (i_wsel_1 == ENT_SEL'(i))) begin
                w_busy_nxt[i]    = 1'b1;
                w_op_nxt[i]      = i_op_1;
                w_dst_tag_nxt[i] = i_dst_tag_1;
                w_s1_tag_nxt[i]  = i_src1_tag_1;
                w_s1_rdy_nxt[i]  = w_d1_s1[DATA_WIDTH];
                w_s1_data_nxt[i] = w_d1_s1[DATA_WIDTH-1:0];
                w_s2_tag_nxt[i]  = i_src2_tag_1;
                w_s2_rdy_nxt[i]  = w_d1_s2[DATA_WIDTH];
                w_s2_data_nxt[i] = w_d1_s2[DATA_WIDTH-1:0];
            end else begin
                w_busy_nxt[i] = r_busy[i] & ~(w_fire && (w_sel == ENT_SEL'(i)));
                // Idle entries must not pick up stray broadcasts.
                if (r_busy[i]) begin
                    w_s1_rdy_nxt[i]  = w_s1_wake[i][DATA_WIDTH];
                    w_s1_data_nxt[i] = w_s1_wake[i][DATA_WIDTH-1:0];
                    w_s2_rdy_nxt[i]  = w_s2_wake[i][DATA_WIDTH];
                    w_s2_data_nxt[i] = w_s2_wake[i][DATA_WIDTH-1:0];
                end else begin
                    w_s1_rdy_nxt[i]  = r_s1_rdy[i];
                    w_s1_data_nxt[i] = r_s1_data[i];
                    w_s2_rdy_nxt[i]  = r_s2_rdy[i];
                    w_s2_data_nxt[i] = r_s2_data[i];
                end
            end
        end
    end

    // Entry state registers; asynchronous reset empties the station immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy    <= '0;
            r_op      <= '0;
            r_dst_tag <= '0;
            r_s1_rdy  <= '0;
            r_s1_tag  <= '0;
            r_s1_data <= '0;
            r_s2_rdy  <= '0;
            r_s2_tag  <= '0;
            r_s2_data <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_op      <= w_op_nxt;
            r_dst_tag <= w_dst_tag_nxt;
            r_s1_rdy  <= w_s1_rdy_nxt;
            r_s1_tag  <= w_s1_tag_nxt;
            r_s1_data <= w_s1_data_nxt;
            r_s2_rdy  <= w_s2_rdy_nxt;
            r_s2_tag  <= w_s2_tag_nxt;
            r_s2_data <= w_s2_data_nxt;
        end
    end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: dispatch, CDB wakeup/bypass, issue priority,
// backpressure, flush and asynchronous reset.
module tb_rs_alu;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_we_1, i_we_2;
    logic [1:0]  i_wsel_1, i_wsel_2;
    logic [4:0]  i_op_1, i_op_2;
    logic [5:0]  i_dst_tag_1, i_dst_tag_2;
    logic        i_src1_rdy_1, i_src2_rdy_1, i_src1_rdy_2, i_src2_rdy_2;
    logic [31:0] i_src1_data_1, i_src2_data_1, i_src1_data_2, i_src2_data_2;
    logic [5:0]  i_src1_tag_1, i_src2_tag_1, i_src1_tag_2, i_src2_tag_2;
    logic        i_cdb_vld_1, i_cdb_vld_2;
    logic [5:0]  i_cdb_tag_1, i_cdb_tag_2;
    logic [31:0] i_cdb_data_1, i_cdb_data_2;
    logic        i_issue_rdy;
    logic [3:0]  o_busy_vec;
    logic        o_issue_vld;
    logic [4:0]  o_issue_op;
    logic [31:0] o_issue_src1, o_issue_src2;
    logic [5:0]  o_issue_dst_tag;

    int n_checks = 0;
    int n_fail   = 0;

    rs_alu dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_we_1(i_we_1), .i_wsel_1(i_wsel_1), .i_op_1(i_op_1), .i_dst_tag_1(i_dst_tag_1),
        .i_src1_rdy_1(i_src1_rdy_1), .i_src1_data_1(i_src1_data_1), .i_src1_tag_1(i_src1_tag_1),
        .i_src2_rdy_1(i_src2_rdy_1), .i_src2_data_1(i_src2_data_1), .i_src2_tag_1(i_src2_tag_1),
        .i_we_2(i_we_2), .i_wsel_2(i_wsel_2), .i_op_2(i_op_2), .i_dst_tag_2(i_dst_tag_2),
        .i_src1_rdy_2(i_src1_rdy_2), .i_src1_data_2(i_src1_data_2), .i_src1_tag_2(i_src1_tag_2),
        .i_src2_rdy_2(i_src2_rdy_2), .i_src2_data_2(i_src2_data_2), .i_src2_tag_2(i_src2_tag_2),
        .i_cdb_vld_1(i_cdb_vld_1), .i_cdb_tag_1(i_cdb_tag_1), .i_cdb_data_1(i_cdb_data_1),
        .i_cdb_vld_2(i_cdb_vld_2), .i_cdb_tag_2(i_cdb_tag_2), .i_cdb_data_2(i_cdb_data_2),
        .i_issue_rdy(i_issue_rdy), .o_busy_vec(o_busy_vec), .o_issue_vld(o_issue_vld),
        .o_issue_op(o_issue_op), .o_issue_src1(o_issue_src1), .o_issue_src2(o_issue_src2),
        .o_issue_dst_tag(o_issue_dst_tag)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        i_flush     = 1'b0;
        i_we_1      = 1'b0;
        i_we_2      = 1'b0;
        i_cdb_vld_1 = 1'b0;
        i_cdb_vld_2 = 1'b0;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic drive_slot(input int k, input logic [1:0] sel, input logic [4:0] op,
                              input logic [5:0] dst,
                              input logic r1, input logic [31:0] d1, input logic [5:0] t1,
                              input logic r2, input logic [31:0] d2, input logic [5:0] t2);
        if (k == 1) begin
            i_we_1 = 1'b1; i_wsel_1 = sel; i_op_1 = op; i_dst_tag_1 = dst;
            i_src1_rdy_1 = r1; i_src1_data_1 = d1; i_src1_tag_1 = t1;
            i_src2_rdy_1 = r2; i_src2_data_1 = d2; i_src2_tag_1 = t2;
        end else begin
            i_we_2 = 1'b1; i_wsel_2 = sel; i_op_2 = op; i_dst_tag_2 = dst;
            i_src1_rdy_2 = r1; i_src1_data_2 = d1; i_src1_tag_2 = t1;
            i_src2_rdy_2 = r2; i_src2_data_2 = d2; i_src2_tag_2 = t2;
        end
    endtask

    task automatic drive_cdb(input int k, input logic [5:0] tag, input logic [31:0] data);
        if (k == 1) begin
            i_cdb_vld_1 = 1'b1; i_cdb_tag_1 = tag; i_cdb_data_1 = data;
        end else begin
            i_cdb_vld_2 = 1'b1; i_cdb_tag_2 = tag; i_cdb_data_2 = data;
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_issue_rdy = 1'b0;
        idle();
        drive_slot(1, 2'd0, 5'd0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0);
        drive_slot(2, 2'd0, 5'd0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0);
        drive_cdb(1, 6'd0, 32'h0);
        drive_cdb(2, 6'd0, 32'h0);
        idle();
        step();
        step();
        check_eq("rst_busy", {28'h0, o_busy_vec}, 32'h0);
        check_eq("rst_vld", {31'h0, o_issue_vld}, 32'h0);
        check_eq("rst_src1", o_issue_src1, 32'h0);
        check_eq("rst_dst", {26'h0, o_issue_dst_tag}, 32'h0);
        i_rst_n = 1'b1;

        // Full-ready dispatch to entry 2, issued and freed on the next edge.
        i_issue_rdy = 1'b1;
        drive_slot(1, 2'd2, 5'd3, 6'd11, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0);
        step();
        check_eq("full_vld", {31'h0, o_issue_vld}, 32'h1);
        check_eq("full_src1", o_issue_src1, 32'd5);
        check_eq("full_src2", o_issue_src2, 32'd7);
        check_eq("full_op", {27'h0, o_issue_op}, 32'd3);
        check_eq("full_dst", {26'h0, o_issue_dst_tag}, 32'd11);
        check_eq("full_busy", {28'h0, o_busy_vec}, 32'h4);
        step();
        check_eq("full_freed", {28'h0, o_busy_vec}, 32'h0);
        check_eq("full_idle_vld", {31'h0, o_issue_vld}, 32'h0);

        // Dispatch/CDB bypass into entry 0.
        i_issue_rdy = 1'b0;
        drive_slot(1, 2'd0, 5'd1, 6'd12, 1'b0, 32'h0, 6'd9, 1'b1, 32'd3, 6'd0);
        drive_cdb(1, 6'd9, 32'hAA);
        step();
        check_eq("byp_vld", {31'h0, o_issue_vld}, 32'h1);
        check_eq("byp_src1", o_issue_src1, 32'hAA);
        check_eq("byp_src2", o_issue_src2, 32'd3);
        i_issue_rdy = 1'b1;
        step();
        check_eq("byp_freed", {28'h0, o_busy_vec}, 32'h0);

        // Entry 1 waits on two tags; CDB 2 wins when both buses carry tag 5.
        i_issue_rdy = 1'b0;
        drive_slot(1, 2'd1, 5'd4, 6'd20, 1'b0, 32'h0, 6'd5, 1'b0, 32'h0, 6'd6);
        step();
        check_eq("wait_busy", {28'h0, o_busy_vec}, 32'h2);
        check_eq("wait_vld", {31'h0, o_issue_vld}, 32'h0);
        drive_cdb(1, 6'd5, 32'h11);
        drive_cdb(2, 6'd5, 32'h22);
        step();
        check_eq("half_vld", {31'h0, o_issue_vld}, 32'h0);
        drive_cdb(2, 6'd6, 32'h33);
        step();
        check_eq("wake_vld", {31'h0, o_issue_vld}, 32'h1);
        check_eq("wake_src1_cdb2", o_issue_src1, 32'h22);
        check_eq("wake_src2", o_issue_src2, 32'h33);

        // Entry 3 also ready; entry 1 holds the output under backpressure.
        drive_slot(2, 2'd3, 5'd9, 6'd7, 1'b1, 32'h44, 6'd0, 1'b1, 32'h55, 6'd0);
        step();
        for (int c = 0; c < 3; c++) begin
            check_eq("bp_dst", {26'h0, o_issue_dst_tag}, 32'd20);
            check_eq("bp_src1", o_issue_src1, 32'h22);
            step();
        end
        check_eq("bp_busy", {28'h0, o_busy_vec}, 32'hA);
        i_issue_rdy = 1'b1;
        step();
        check_eq("prio_second_dst", {26'h0, o_issue_dst_tag}, 32'd7);
        check_eq("prio_second_src1", o_issue_src1, 32'h44);
        check_eq("prio_busy", {28'h0, o_busy_vec}, 32'h8);
        step();
        check_eq("prio_empty", {28'h0, o_busy_vec}, 32'h0);

        // Fill all four entries with nothing ready, then wake entry 2.
        i_issue_rdy = 1'b0;
        drive_slot(1, 2'd0, 5'd1, 6'd30, 1'b0, 32'h0, 6'd20, 1'b0, 32'h0, 6'd21);
        drive_slot(2, 2'd1, 5'd1, 6'd31, 1'b0, 32'h0, 6'd22, 1'b0, 32'h0, 6'd23);
        step();
        drive_slot(1, 2'd2, 5'd2, 6'd32, 1'b0, 32'h0, 6'd12, 1'b0, 32'h0, 6'd13);
        drive_slot(2, 2'd3, 5'd3, 6'd33, 1'b0, 32'h0, 6'd24, 1'b0, 32'h0, 6'd25);
        step();
        check_eq("fill_busy", {28'h0, o_busy_vec}, 32'hF);
        check_eq("fill_vld", {31'h0, o_issue_vld}, 32'h0);
        drive_cdb(1, 6'd12, 32'h100);
        drive_cdb(2, 6'd13, 32'h200);
        step();
        check_eq("fill_wake_vld", {31'h0, o_issue_vld}, 32'h1);
        check_eq("fill_wake_dst", {26'h0, o_issue_dst_tag}, 32'd32);
        check_eq("fill_wake_src1", o_issue_src1, 32'h100);
        check_eq("fill_wake_src2", o_issue_src2, 32'h200);
        i_issue_rdy = 1'b1;
        step();
        check_eq("fill_after_issue", {28'h0, o_busy_vec}, 32'hB);

        // Both slots target entry 2: slot 2 wins.
        i_issue_rdy = 1'b0;
        drive_slot(1, 2'd2, 5'd5, 6'd1, 1'b1, 32'h61, 6'd0, 1'b1, 32'h62, 6'd0);
        drive_slot(2, 2'd2, 5'd6, 6'd2, 1'b1, 32'h71, 6'd0, 1'b1, 32'h72, 6'd0);
        step();
        check_eq("coll_dst", {26'h0, o_issue_dst_tag}, 32'd2);
        check_eq("coll_src1", o_issue_src1, 32'h71);
        // Entry 2 fires while being rewritten: the write survives.
        i_issue_rdy = 1'b1;
        drive_slot(1, 2'd2, 5'd7, 6'd3, 1'b1, 32'h81, 6'd0, 1'b1, 32'h82, 6'd0);
        step();
        check_eq("fire_write_busy", {28'h0, o_busy_vec}, 32'hF);
        check_eq("fire_write_dst", {26'h0, o_issue_dst_tag}, 32'd3);
        check_eq("fire_write_src2", o_issue_src2, 32'h82);

        // Flush beats a same-cycle write.
        i_flush = 1'b1;
        drive_slot(1, 2'd0, 5'd1, 6'd4, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2, 6'd0);
        step();
        check_eq("flush_busy", {28'h0, o_busy_vec}, 32'h0);
        check_eq("flush_vld", {31'h0, o_issue_vld}, 32'h0);

        // Asynchronous reset mid-operation.
        i_issue_rdy = 1'b0;
        drive_slot(1, 2'd0, 5'd8, 6'd40, 1'b1, 32'h91, 6'd0, 1'b1, 32'h92, 6'd0);
        step();
        check_eq("pre_rst_vld", {31'h0, o_issue_vld}, 32'h1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("arst_busy", {28'h0, o_busy_vec}, 32'h0);
        check_eq("arst_vld", {31'h0, o_issue_vld}, 32'h0);
        check_eq("arst_src1", o_issue_src1, 32'h0);
        check_eq("arst_op", {27'h0, o_issue_op}, 32'h0);
        drive_slot(1, 2'd1, 5'd8, 6'd41, 1'b1, 32'h93, 6'd0, 1'b1, 32'h94, 6'd0);
        @(posedge i_clk);
        #1;
        check_eq("arst_ignore_we", {28'h0, o_busy_vec}, 32'h0);
        idle();
        i_rst_n = 1'b1;
        step();
        check_eq("post_rst_busy", {28'h0, o_busy_vec}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
